fetch_unit: RTL



---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the fetch PC, issues word requests to a variable-latency instruction
// memory under a credit limit, buffers PC-tagged responses in a small FIFO and
// hands them to decode over valid/ready. Redirects flush the buffer and arrange
// for responses still in flight on the old path to be discarded.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   imem_req_valid/addr   fetch request out (word aligned)
//   imem_req_ready        memory accepts the request this cycle
//   imem_rsp_valid/data   in-order response word from memory
//   redirect_valid/pc     branch/jump target from the datapath
//   inst_valid/inst/pc    FIFO head offered to decode
//   inst_ready            decode consumes the head this cycle
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             req_valid_q, req_valid_d;
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];

  logic             accept;
  logic             rsp_drop;
  logic             rsp_take;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] out_next;
  logic [31:0]      redir_target;
  logic             unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_target     = {redirect_pc[31:2], 2'b00};

  // Outputs come straight from registers (inst_valid only decodes cnt_q)
  assign imem_req_valid = req_valid_q;
  assign imem_addr      = fetch_pc_q;
  assign inst_valid     = (cnt_q != '0);
  assign inst           = fifo_data_q[rd_ptr_q];
  assign inst_pc        = fifo_pc_q[rd_ptr_q];

  // Next-state: issue, response classification, dequeue, redirect override
  always_comb begin
    accept      = req_valid_q && imem_req_ready;
    rsp_drop    = imem_rsp_valid && (disc_q != '0);
    rsp_take    = imem_rsp_valid && (disc_q == '0) && (out_q != '0);
    pop         = inst_valid && inst_ready;
    // A response in the redirect cycle still retires its credit but is not kept
    push        = rsp_take && !redirect_valid;
    out_next    = out_q + CNT_W'(accept) - CNT_W'(rsp_take);

    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    out_d       = out_next;
    disc_d      = disc_q - CNT_W'(rsp_drop);
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    req_valid_d = 1'b0;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Everything still in flight becomes wrong-path and is dropped on return
    if (redirect_valid) begin
      fetch_pc_d = redir_target;
      rsp_pc_d   = redir_target;
      disc_d     = disc_q - CNT_W'(rsp_drop) + out_next;
      out_d      = '0;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end

    // Credit check on the values the counters will hold next cycle
    req_valid_d = (SUM_W'(out_d) + SUM_W'(disc_d) + SUM_W'(cnt_d)) < SUM_W'(FIFO_DEPTH);
  end

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      out_q       <= '0;
      disc_q      <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      out_q       <= out_d;
      disc_q      <= disc_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      req_valid_q <= req_valid_d;
    end
  end

  // Instruction buffer storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule
